// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: bus width and the memory-access sequencer state encoding.
package lc3_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    MAC_IDLE = 3'd0,
    MAC_MAR  = 3'd1,
    MAC_MDRW = 3'd2,
    MAC_WAIT = 3'd3,
    MAC_GATE = 3'd4,
    MAC_DONE = 3'd5
  } macState_t;

  // The only states that put a value on the bus toward MAR/MDR.
  function automatic logic drivesBus(input macState_t s);
    return (s == MAC_MAR) || (s == MAC_MDRW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester handshake plus LC-3 MAR/MDR memory-unit signals for mem_access_ctrl.
interface mem_access_ctrl_if #(
    parameter int DATA_W = lc3_pkg::DATA_W
);
    // Request: a transfer happens on a rising edge where req_valid && req_ready;
    // req_* are sampled only on that edge. Response: rsp_valid is a one-cycle
    // pulse with no back-pressure; rsp_err and rsp_rdata qualify it.
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] mdr_in;
    logic              LDMAR;
    logic              LDMDR;
    logic              MIOEN;
    logic              RW;
    logic              GateMDR;
    logic              R;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mdr_in, R,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_out,
               LDMAR, LDMDR, MIOEN, RW, GateMDR
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mdr_in, R,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_out,
               LDMAR, LDMDR, MIOEN, RW, GateMDR
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one read or write onto the LC-3 MAR/MDR memory unit per request,
// with a bounded wait on memory ready R.
module mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int DATA_W  = lc3_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus,
    output macState_t          dbgState
);

    macState_t         state;
    macState_t         nextState;
    logic              latWrite;
    logic [DATA_W-1:0] latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [7:0]        waitCnt;
    logic              errFlag;
    logic [DATA_W-1:0] rdataQ;
    logic              accept;
    logic              timedOut;

    assign accept   = bus.req_valid && (state == MAC_IDLE);
    assign timedOut = !bus.R && (waitCnt == 8'(TIMEOUT));
    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MAC_IDLE;
            latWrite <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            waitCnt  <= '0;
            errFlag  <= 1'b0;
            rdataQ   <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                latWrite <= bus.req_write;
                latAddr  <= bus.req_addr;
                latWdata <= bus.req_wdata;
            end
            case (state)
                MAC_WAIT: begin
                    if (bus.R) begin
                        waitCnt <= '0;
                    end else if (timedOut) begin
                        waitCnt <= '0;
                        errFlag <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                MAC_GATE: rdataQ  <= bus.mdr_in;
                MAC_DONE: errFlag <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            MAC_IDLE: if (accept) nextState = MAC_MAR;
            MAC_MAR:  nextState = latWrite ? MAC_MDRW : MAC_WAIT;
            MAC_MDRW: nextState = MAC_WAIT;
            MAC_WAIT: begin
                if (bus.R)         nextState = latWrite ? MAC_DONE : MAC_GATE;
                else if (timedOut) nextState = MAC_DONE;
            end
            MAC_GATE: nextState = MAC_DONE;
            MAC_DONE: nextState = MAC_IDLE;
            default:  nextState = MAC_IDLE;
        endcase
    end

    // Moore decode of the state register; MDR is loaded from the bus only in MDRW.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.bus_out   = '0;
        bus.LDMAR     = 1'b0;
        bus.LDMDR     = 1'b0;
        bus.MIOEN     = 1'b0;
        bus.RW        = 1'b0;
        bus.GateMDR   = 1'b0;
        case (state)
            MAC_IDLE: bus.req_ready = 1'b1;
            MAC_MAR: begin
                bus.LDMAR = 1'b1;
            end
            MAC_MDRW: begin
                bus.LDMDR = 1'b1;
            end
            MAC_WAIT: begin
                bus.MIOEN = 1'b1;
                bus.RW    = latWrite;
                bus.LDMDR = !latWrite;
            end
            MAC_GATE: bus.GateMDR = 1'b1;
            MAC_DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = errFlag;
            end
            default: ;
        endcase
        if (drivesBus(state)) begin
            bus.bus_out = (state == MAC_MAR) ? latAddr : latWdata;
        end
    end

    assign bus.rsp_rdata = rdataQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small MAR/MDR memory model and programmable R delay.
module tb_mem_access_ctrl;
  import lc3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(16)) bus();
  macState_t dbg_state;

  mem_access_ctrl #(.DATA_W(16), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // memory unit model: MAR/MDR registers, word store, R after r_delay WAIT cycles
  logic [15:0] mem [logic [15:0]];
  logic [15:0] mar_m = 16'h0;
  logic [15:0] mdr_m = 16'h0;
  int wait_seen = 0;
  int r_delay = 0;

  always @(posedge clk) begin
    if (bus.LDMAR) mar_m <= bus.bus_out;
    if (bus.LDMDR && !bus.MIOEN) mdr_m <= bus.bus_out;
    if (bus.MIOEN && bus.RW && bus.R) mem[mar_m] = mdr_m;
    if (bus.MIOEN && !bus.RW && bus.LDMDR) mdr_m <= mem.exists(mar_m) ? mem[mar_m] : 16'h0;
    wait_seen <= bus.MIOEN ? wait_seen + 1 : 0;
  end

  assign bus.R      = bus.MIOEN && (wait_seen >= r_delay);
  assign bus.mdr_in = mdr_m;

  // driver: called at a negedge in IDLE, returns at the negedge of cycle 1 (MAR)
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input int dly);
    r_delay = dly;
    bus.req_write = wr;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr = 16'hDEAD;
    bus.req_wdata = 16'hDEAD;
  endtask

  // driver: follows a transaction from cycle 1 until rsp_valid (lat = -1 if it never comes)
  task automatic wait_rsp(output int lat, output logic [15:0] rdata, output logic err,
                          output logic ldmar1, output logic [15:0] bus1, output logic [15:0] bus2,
                          output int wait_cyc, output int ldmdr_wait);
    int cyc = 1;
    lat = -1; rdata = 16'hxxxx; err = 1'bx;
    wait_cyc = 0; ldmdr_wait = 0; bus2 = 16'h0;
    ldmar1 = bus.LDMAR;
    bus1 = bus.bus_out;
    while (cyc < 200) begin
      if (cyc == 2) bus2 = bus.bus_out;
      if (bus.MIOEN) begin
        wait_cyc++;
        if (bus.LDMDR) ldmdr_wait++;
      end
      if (bus.rsp_valid) begin
        lat = cyc; rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  int lat, wc, lw;
  logic [15:0] rd, b1, b2;
  logic er, lm;

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== MAC_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, MAC_IDLE); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if ({bus.LDMAR, bus.LDMDR, bus.MIOEN, bus.RW, bus.GateMDR} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {bus.LDMAR, bus.LDMDR, bus.MIOEN, bus.RW, bus.GateMDR}); end
    checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b0) begin errors++; $display("FAIL reset_rsp got %b want 00", {bus.rsp_valid, bus.rsp_err}); end
    checks++; if (bus.bus_out !== 16'h0 || bus.rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_data got bus %h rdata %h want 0 0", bus.bus_out, bus.rsp_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_fast();
    issue(1'b0, 16'h3000, 16'h0, 0);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (lm !== 1'b1 || b1 !== 16'h3000) begin errors++; $display("FAIL rd_mar got ldmar %b bus %h want 1 3000", lm, b1); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got %0d want 4", lat); end
    checks++; if (rd !== 16'h1234 || er !== 1'b0) begin errors++; $display("FAIL rd_data got %h err %b want 1234 0", rd, er); end
    checks++; if (wc !== 1 || b2 !== 16'h0) begin errors++; $display("FAIL rd_wait got %0d bus2 %h want 1 0", wc, b2); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    issue(1'b1, 16'h4001, 16'hBEEF, 0);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (b1 !== 16'h4001 || b2 !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got %h %h want 4001 beef", b1, b2); end
    checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL wr_latency got %0d err %b want 4 0", lat, er); end
    checks++; if (lw !== 0) begin errors++; $display("FAIL wr_ldmdr_in_wait got %0d want 0", lw); end
    @(negedge clk);
    issue(1'b0, 16'h4001, 16'h0, 0);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (lat !== 4 || rd !== 16'hBEEF) begin errors++; $display("FAIL wr_readback got lat %0d data %h want 4 beef", lat, rd); end
    @(negedge clk);
  endtask

  task automatic test_read_delay();
    issue(1'b0, 16'h3000, 16'h0, 5);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (lat !== 9) begin errors++; $display("FAIL dly_latency got %0d want 9", lat); end
    checks++; if (wc !== 6 || lw !== 6) begin errors++; $display("FAIL dly_wait got wait %0d ldmdr %0d want 6 6", wc, lw); end
    checks++; if (rd !== 16'h1234 || er !== 1'b0) begin errors++; $display("FAIL dly_data got %h err %b want 1234 0", rd, er); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    issue(1'b0, 16'h5000, 16'h0, 1000);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (lat !== 18 || wc !== 16) begin errors++; $display("FAIL to_latency got lat %0d wait %0d want 18 16", lat, wc); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", er); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL to_rdata_held got %h want 1234", rd); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL to_after got valid %b err %b ready %b want 0 0 1", bus.rsp_valid, bus.rsp_err, bus.req_ready); end
    issue(1'b0, 16'h3000, 16'h0, 0);
    wait_rsp(lat, rd, er, lm, b1, b2, wc, lw);
    checks++; if (lat !== 4 || er !== 1'b0 || rd !== 16'h1234) begin
      errors++; $display("FAIL to_recover got lat %0d err %b data %h want 4 0 1234", lat, er, rd); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(1'b0, 16'h3000, 16'h0, 1000);
    @(negedge clk);
    checks++; if (bus.MIOEN !== 1'b1) begin errors++; $display("FAIL rm_in_wait got mioen %b want 1", bus.MIOEN); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.LDMAR, bus.LDMDR, bus.MIOEN, bus.RW, bus.GateMDR} !== 5'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rm_ctrl got %b ready %b want 00000 1", {bus.LDMAR, bus.LDMDR, bus.MIOEN, bus.RW, bus.GateMDR}, bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL rm_rsp got valid %b rdata %h want 0 0", bus.rsp_valid, bus.rsp_rdata); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rm_no_pulse got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int ready_bad = 0;
    r_delay = 0;
    bus.req_write = 1'b0;
    bus.req_addr = 16'h3000;
    bus.req_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.req_ready !== (k == 5)) ready_bad++;
      if (k == 4) begin
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h1234) begin
          errors++; $display("FAIL b2b_first got valid %b data %h want 1 1234", bus.rsp_valid, bus.rsp_rdata); end
      end
      if (k == 9) begin
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h5A5A) begin
          errors++; $display("FAIL b2b_second got valid %b data %h want 1 5a5a", bus.rsp_valid, bus.rsp_rdata); end
        bus.req_valid = 1'b0;
      end
      bus.req_addr = 16'h3000 + 16'(k);
    end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready got %0d bad cycles want 0", ready_bad); end
    @(negedge clk);
  endtask

  initial begin
    mem[16'h3000] = 16'h1234;
    mem[16'h3005] = 16'h5A5A;
    test_reset();
    test_read_fast();
    test_write_read();
    test_read_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
